// File: rtl/axi_xbar_if.sv
// AXI4-Lite crossbar bundle: one master-side channel set plus NSLV slave-side
// channel sets. Write/read addresses and write data are broadcast to every
// slave, and each slave has its own valid/ready/resp bits. Read data is packed,
// with slice i belonging to slave i.
//
// Modports:
//   slave  - the crossbar's view. It is the slave of the shared master bus and
//            fans out to the devices.
//   master - the surrounding world's view: the upstream master plus the
//            downstream devices.
interface axi_xbar_if #(parameter int NSLV = 2);
    // master side
    logic                       m_arvalid, m_arready;
    logic [31:0]                m_araddr;
    logic                       m_rvalid, m_rready;
    logic [31:0]                m_rdata;
    logic                       m_rresp;
    logic                       m_awvalid, m_awready;
    logic [31:0]                m_awaddr;
    logic                       m_wvalid, m_wready;
    logic [31:0]                m_wdata;
    logic [7:0]                 m_wmask;
    logic                       m_bvalid, m_bready;
    logic                       m_bresp;
    // slave side
    logic [NSLV-1:0]            s_arvalid, s_arready;
    logic [31:0]                s_araddr;
    logic [NSLV-1:0]            s_rvalid, s_rready;
    logic [NSLV-1:0][31:0]      s_rdata;
    logic [NSLV-1:0]            s_rresp;
    logic [NSLV-1:0]            s_awvalid, s_awready;
    logic [31:0]                s_awaddr;
    logic [NSLV-1:0]            s_wvalid, s_wready;
    logic [31:0]                s_wdata;
    logic [7:0]                 s_wmask;
    logic [NSLV-1:0]            s_bvalid, s_bready;
    logic [NSLV-1:0]            s_bresp;

    modport slave (
        input  m_arvalid, m_araddr, m_rready, m_awvalid, m_awaddr,
               m_wvalid, m_wdata, m_wmask, m_bready,
        output m_arready, m_rvalid, m_rdata, m_rresp, m_awready, m_wready,
               m_bvalid, m_bresp,
        output s_arvalid, s_araddr, s_rready, s_awvalid, s_awaddr,
               s_wvalid, s_wdata, s_wmask, s_bready,
        input  s_arready, s_rvalid, s_rdata, s_rresp, s_awready, s_wready,
               s_bvalid, s_bresp
    );

    modport master (
        output m_arvalid, m_araddr, m_rready, m_awvalid, m_awaddr,
               m_wvalid, m_wdata, m_wmask, m_bready,
        input  m_arready, m_rvalid, m_rdata, m_rresp, m_awready, m_wready,
               m_bvalid, m_bresp,
        input  s_arvalid, s_araddr, s_rready, s_awvalid, s_awaddr,
               s_wvalid, s_wdata, s_wmask, s_bready,
        output s_arready, s_rvalid, s_rdata, s_rresp, s_awready, s_wready,
               s_bvalid, s_bresp
    );
endinterface

// File: rtl/axi_xbar.sv
// axi_xbar - AXI4-Lite crossbar from one master to NSLV slaves, decoded by
// address.
//
// Ports:
//   clk   - clock
//   reset - synchronous, active-high reset
//   bus   - axi_xbar_if.slave. It carries the master channel set (AR/R/AW/W/B)
//           and the per-slave channel sets.
//
// Decode: slave i hits when (addr & MASK[i]) == BASE[i]. When several slaves
// hit, the lowest index wins. An address that hits no slave is answered
// locally with resp=1 and is never forwarded.
//
// The read and write FSMs are independent. Each allows one transaction in
// flight. Channel signals are pure muxes on the registered state, so each
// channel adds no cycles. The only extra cycle is the state step between the
// address phase and the data/response phase.
module axi_xbar #(
    parameter int                   NSLV      = 2,
    parameter logic [NSLV*32-1:0]   ADDR_BASE = {32'ha000_0000, 32'h8000_0000},
    parameter logic [NSLV*32-1:0]   ADDR_MASK = {32'hffff_0000, 32'hf800_0000}
) (
    input  logic        clk,
    input  logic        reset,
    axi_xbar_if.slave   bus
);
    localparam int SELW = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {R_IDLE, R_DATA, R_ERR} r_state_t;
    typedef enum logic [2:0] {W_IDLE, W_DATA, W_RESP, W_ERRW, W_ERRB} w_state_t;

    r_state_t          r_state;
    w_state_t          w_state;
    logic [SELW-1:0]   sel_r, sel_w;

    // Returns {hit, index}. The loop runs downward so the lowest matching
    // index is the last one written, and therefore the one that wins.
    function automatic logic [SELW:0] decode(input logic [31:0] addr);
        logic [SELW:0] r;
        r = '0;
        for (int i = NSLV - 1; i >= 0; i--)
            if ((addr & ADDR_MASK[i*32 +: 32]) == ADDR_BASE[i*32 +: 32])
                r = {1'b1, SELW'(i)};
        return r;
    endfunction

    logic [SELW:0] ar_dec, aw_dec;
    logic          ar_hit, aw_hit;
    logic [SELW-1:0] ar_idx, aw_idx;

    assign ar_dec = decode(bus.m_araddr);
    assign aw_dec = decode(bus.m_awaddr);
    assign ar_hit = ar_dec[SELW];
    assign aw_hit = aw_dec[SELW];
    assign ar_idx = ar_dec[SELW-1:0];
    assign aw_idx = aw_dec[SELW-1:0];

    // Addresses and write payload go to every slave. The valids steer them.
    assign bus.s_araddr = bus.m_araddr;
    assign bus.s_awaddr = bus.m_awaddr;
    assign bus.s_wdata  = bus.m_wdata;
    assign bus.s_wmask  = bus.m_wmask;

    // ---------------- read path ----------------
    always_comb begin
        bus.s_arvalid = '0;
        bus.s_rready  = '0;
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b0;
        bus.m_rdata   = '0;
        bus.m_rresp   = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (ar_hit) begin
                    bus.s_arvalid[ar_idx] = bus.m_arvalid;
                    bus.m_arready         = bus.s_arready[ar_idx];
                end else begin
                    // A miss is accepted at once and answered locally.
                    bus.m_arready = bus.m_arvalid;
                end
            end
            R_DATA: begin
                bus.m_rvalid         = bus.s_rvalid[sel_r];
                bus.m_rdata          = bus.s_rdata[sel_r];
                bus.m_rresp          = bus.s_rresp[sel_r];
                bus.s_rready[sel_r]  = bus.m_rready;
            end
            R_ERR: begin
                bus.m_rvalid = 1'b1;
                bus.m_rresp  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
            sel_r   <= '0;
        end else begin
            case (r_state)
                R_IDLE:
                    if (bus.m_arvalid && bus.m_arready) begin
                        if (ar_hit) begin
                            sel_r   <= ar_idx;
                            r_state <= R_DATA;
                        end else begin
                            r_state <= R_ERR;
                        end
                    end
                R_DATA:
                    if (bus.m_rvalid && bus.m_rready) r_state <= R_IDLE;
                R_ERR:
                    if (bus.m_rready) r_state <= R_IDLE;
                default:
                    r_state <= R_IDLE;
            endcase
        end
    end

    // ---------------- write path ----------------
    // W is held off (m_wready=0) until AW has been taken. The W beat then
    // goes to the slave latched from AW, not to whatever m_awaddr shows now.
    always_comb begin
        bus.s_awvalid = '0;
        bus.s_wvalid  = '0;
        bus.s_bready  = '0;
        bus.m_awready = 1'b0;
        bus.m_wready  = 1'b0;
        bus.m_bvalid  = 1'b0;
        bus.m_bresp   = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_hit) begin
                    bus.s_awvalid[aw_idx] = bus.m_awvalid;
                    bus.m_awready         = bus.s_awready[aw_idx];
                end else begin
                    bus.m_awready = bus.m_awvalid;
                end
            end
            W_DATA: begin
                bus.s_wvalid[sel_w] = bus.m_wvalid;
                bus.m_wready        = bus.s_wready[sel_w];
            end
            W_RESP: begin
                bus.m_bvalid        = bus.s_bvalid[sel_w];
                bus.m_bresp         = bus.s_bresp[sel_w];
                bus.s_bready[sel_w] = bus.m_bready;
            end
            W_ERRW: bus.m_wready = 1'b1;     // swallow the data beat
            W_ERRB: begin
                bus.m_bvalid = 1'b1;
                bus.m_bresp  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state <= W_IDLE;
            sel_w   <= '0;
        end else begin
            case (w_state)
                W_IDLE:
                    if (bus.m_awvalid && bus.m_awready) begin
                        if (aw_hit) begin
                            sel_w   <= aw_idx;
                            w_state <= W_DATA;
                        end else begin
                            w_state <= W_ERRW;
                        end
                    end
                W_DATA:
                    if (bus.m_wvalid && bus.m_wready) w_state <= W_RESP;
                W_RESP:
                    if (bus.m_bvalid && bus.m_bready) w_state <= W_IDLE;
                W_ERRW:
                    if (bus.m_wvalid) w_state <= W_ERRB;
                W_ERRB:
                    if (bus.m_bready) w_state <= W_IDLE;
                default:
                    w_state <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_xbar.sv
// Directed bench for axi_xbar. Inputs change 1 time unit after the rising
// edge, and everything is sampled on the falling edge. A transaction-level
// model predicts every crossbar output on every cycle. It tracks which slave
// (or the local error responder) owns the outstanding read, and the phase and
// owner of the outstanding write. Literal checks at chosen points pin that
// model to hand-computed values.
module tb_axi_xbar;
    localparam int NSLV = 2;
    localparam logic [31:0] BASE [NSLV] = '{32'h8000_0000, 32'ha000_0000};
    localparam logic [31:0] MASK [NSLV] = '{32'hf800_0000, 32'hffff_0000};

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    axi_xbar_if #(.NSLV(NSLV)) bus ();

    axi_xbar #(.NSLV(NSLV)) dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", n, got, exp, $time);
        end
    endtask

    // First matching slave, or NSLV when nothing matches.
    function automatic int target(input logic [31:0] a);
        for (int k = 0; k < NSLV; k++)
            if ((a & MASK[k]) == BASE[k]) return k;
        return NSLV;
    endfunction

    // ---------------- model + per-cycle compare ----------------
    int rd_own = -1;          // -1 none, 0..NSLV-1 slave, NSLV local error
    int wr_own = -1;
    int wr_ph  = 0;           // 0 idle, 1 awaiting W, 2 awaiting B

    always @(negedge clk) begin
        int at, wt;
        logic [NSLV-1:0] e_sarv, e_srr, e_sawv, e_swv, e_sbr;
        logic e_arr, e_rv, e_rr, e_awr, e_wr, e_bv, e_br;
        logic [31:0] e_rd;
        if (chk_en) begin
            at = target(bus.m_araddr);
            wt = target(bus.m_awaddr);
            e_sarv = '0; e_srr = '0; e_sawv = '0; e_swv = '0; e_sbr = '0;
            e_arr = 0; e_rv = 0; e_rr = 0; e_rd = '0;
            e_awr = 0; e_wr = 0; e_bv = 0; e_br = 0;

            if (rd_own < 0) begin
                if (at < NSLV) begin
                    e_sarv[at] = bus.m_arvalid;
                    e_arr = bus.s_arready[at];
                end else e_arr = bus.m_arvalid;
            end else if (rd_own < NSLV) begin
                e_rv = bus.s_rvalid[rd_own];
                e_rd = bus.s_rdata[rd_own];
                e_rr = bus.s_rresp[rd_own];
                e_srr[rd_own] = bus.m_rready;
            end else begin
                e_rv = 1; e_rr = 1;
            end

            if (wr_ph == 0) begin
                if (wt < NSLV) begin
                    e_sawv[wt] = bus.m_awvalid;
                    e_awr = bus.s_awready[wt];
                end else e_awr = bus.m_awvalid;
            end else if (wr_ph == 1) begin
                if (wr_own < NSLV) begin
                    e_swv[wr_own] = bus.m_wvalid;
                    e_wr = bus.s_wready[wr_own];
                end else e_wr = 1;
            end else begin
                if (wr_own < NSLV) begin
                    e_bv = bus.s_bvalid[wr_own];
                    e_br = bus.s_bresp[wr_own];
                    e_sbr[wr_own] = bus.m_bready;
                end else begin
                    e_bv = 1; e_br = 1;
                end
            end

            chk("s_arvalid", 64'(bus.s_arvalid), 64'(e_sarv));
            chk("m_arready", 64'(bus.m_arready), 64'(e_arr));
            chk("m_rvalid",  64'(bus.m_rvalid),  64'(e_rv));
            chk("m_rdata",   64'(bus.m_rdata),   64'(e_rd));
            chk("m_rresp",   64'(bus.m_rresp),   64'(e_rr));
            chk("s_rready",  64'(bus.s_rready),  64'(e_srr));
            chk("s_awvalid", 64'(bus.s_awvalid), 64'(e_sawv));
            chk("m_awready", 64'(bus.m_awready), 64'(e_awr));
            chk("s_wvalid",  64'(bus.s_wvalid),  64'(e_swv));
            chk("m_wready",  64'(bus.m_wready),  64'(e_wr));
            chk("m_bvalid",  64'(bus.m_bvalid),  64'(e_bv));
            chk("m_bresp",   64'(bus.m_bresp),   64'(e_br));
            chk("s_bready",  64'(bus.s_bready),  64'(e_sbr));
            chk("bcast",     {bus.s_araddr, bus.s_awaddr}, {bus.m_araddr, bus.m_awaddr});
            chk("bcast_w",   {24'h0, bus.s_wmask, bus.s_wdata}, {24'h0, bus.m_wmask, bus.m_wdata});

            // Inputs are stable until the next rising edge, so the state
            // after that edge can be decided now.
            if (reset) begin
                rd_own = -1; wr_ph = 0; wr_own = -1;
            end else begin
                if (rd_own < 0) begin
                    if (bus.m_arvalid && e_arr) rd_own = at;
                end else if ((rd_own < NSLV) ? (e_rv && bus.m_rready) : bus.m_rready)
                    rd_own = -1;
                case (wr_ph)
                    0: if (bus.m_awvalid && e_awr) begin wr_own = wt; wr_ph = 1; end
                    1: if (bus.m_wvalid && e_wr) wr_ph = 2;
                    default: if ((wr_own < NSLV) ? (e_bv && bus.m_bready) : bus.m_bready)
                        wr_ph = 0;
                endcase
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    logic [31:0] dec_addr [5] = '{32'h87ff_fffc, 32'h8800_0000, 32'ha000_ffff, 32'ha001_0000, 32'h7fff_fffc};
    logic [1:0]  dec_exp  [5] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b00};

    initial begin
        bus.m_arvalid = 0; bus.m_araddr = '0; bus.m_rready = 0;
        bus.m_awvalid = 0; bus.m_awaddr = '0; bus.m_wvalid = 0;
        bus.m_wdata = '0; bus.m_wmask = '0; bus.m_bready = 0;
        bus.s_arready = '0; bus.s_rvalid = '0; bus.s_rdata = '0; bus.s_rresp = '0;
        bus.s_awready = '0; bus.s_wready = '0; bus.s_bvalid = '0; bus.s_bresp = '0;

        cyc(1);
        chk_en = 1'b1;
        cyc(2);
        samp();
        chk("rst_rvalid", 64'(bus.m_rvalid), 64'd0);
        chk("rst_bvalid", 64'(bus.m_bvalid), 64'd0);
        chk("rst_rdata",  64'(bus.m_rdata),  64'd0);
        chk("rst_arready_nohit", 64'(bus.m_arready), 64'd0);
        cyc(1);
        reset = 0;
        bus.s_arready = 2'b11; bus.s_awready = 2'b11; bus.s_wready = 2'b11;
        bus.m_rready = 1; bus.m_bready = 1;

        // read slave0, data 3 cycles after AR
        bus.m_araddr = 32'h8000_0010; bus.m_arvalid = 1;
        samp();
        chk("t1_s_arvalid", 64'(bus.s_arvalid), 64'b01);
        cyc(1);
        bus.m_arvalid = 0;
        cyc(2);
        bus.s_rvalid[0] = 1; bus.s_rdata[0] = 32'h1234_5678;
        samp();
        chk("t1_rdata", {31'h0, bus.m_rvalid, bus.m_rdata}, {31'h0, 1'b1, 32'h1234_5678});
        chk("t1_rresp", 64'(bus.m_rresp), 64'd0);
        cyc(1);
        bus.s_rvalid = '0;

        // write slave1, W offered two cycles before AW
        bus.m_wvalid = 1; bus.m_wdata = 32'h41; bus.m_wmask = 8'h01;
        samp();
        chk("t2_wready_early0", 64'(bus.m_wready), 64'd0);
        cyc(2);
        bus.m_awaddr = 32'ha000_03f8; bus.m_awvalid = 1;
        samp();
        chk("t2_s_awvalid", 64'(bus.s_awvalid), 64'b10);
        chk("t2_wready_early1", 64'(bus.m_wready), 64'd0);
        cyc(1);
        bus.m_awvalid = 0;
        samp();
        chk("t2_s_wvalid", {bus.s_wvalid, bus.s_wmask, bus.s_wdata}, {2'b10, 8'h01, 32'h41});
        cyc(1);
        bus.m_wvalid = 0; bus.s_bvalid[1] = 1; bus.s_bresp[1] = 0;
        samp();
        chk("t2_b", {bus.m_bvalid, bus.m_bresp}, 2'b10);
        cyc(1);
        bus.s_bvalid = '0;

        // unmapped read
        bus.m_araddr = 32'h0000_1000; bus.m_arvalid = 1;
        samp();
        chk("t3_arready", {bus.m_arready, bus.s_arvalid}, 3'b100);
        cyc(1);
        bus.m_arvalid = 0;
        samp();
        chk("t3_r", {bus.m_rvalid, bus.m_rresp, bus.m_rdata}, {2'b11, 32'h0});
        cyc(1);

        // unmapped write
        bus.m_awaddr = 32'h4000_0000; bus.m_awvalid = 1;
        bus.m_wvalid = 1; bus.m_wdata = 32'hdead;
        samp();
        chk("t4_aw", {bus.m_awready, bus.m_wready, bus.s_awvalid}, 4'b1000);
        cyc(1);
        bus.m_awvalid = 0;
        samp();
        chk("t4_w", {bus.m_wready, bus.s_wvalid}, 3'b100);
        cyc(1);
        bus.m_wvalid = 0;
        samp();
        chk("t4_b", {bus.m_bvalid, bus.m_bresp}, 2'b11);
        cyc(1);

        // concurrent read slave1 / write slave0, master stalls R for 4 cycles
        bus.m_rready = 0;
        bus.m_araddr = 32'ha000_0004; bus.m_arvalid = 1;
        bus.m_awaddr = 32'h8000_0020; bus.m_awvalid = 1;
        bus.m_wvalid = 1; bus.m_wdata = 32'h5555_aaaa; bus.m_wmask = 8'h0f;
        cyc(1);
        bus.m_arvalid = 0; bus.m_awvalid = 0;
        bus.s_rvalid[1] = 1; bus.s_rdata[1] = 32'hcafe_0001; bus.s_rresp[1] = 0;
        cyc(1);
        bus.m_wvalid = 0; bus.s_bvalid[0] = 1; bus.s_bresp[0] = 0;
        for (int k = 0; k < 4; k++) begin
            samp();
            chk("t5_rstall", {31'h0, bus.m_rvalid, bus.m_rdata}, {31'h0, 1'b1, 32'hcafe_0001});
            cyc(1);
            bus.s_bvalid = '0;
        end
        bus.m_rready = 1;
        samp();
        chk("t5_rready_fwd", 64'(bus.s_rready), 64'b10);
        cyc(1);
        bus.s_rvalid = '0;

        // reset while in R_DATA and W_RESP, stale response must not leak
        bus.m_araddr = 32'h8000_0000; bus.m_arvalid = 1;
        bus.m_awaddr = 32'ha000_0000; bus.m_awvalid = 1;
        bus.m_wvalid = 1;
        cyc(1);
        bus.m_arvalid = 0; bus.m_awvalid = 0;
        cyc(1);
        bus.m_wvalid = 0;
        reset = 1;
        cyc(1);
        reset = 0;
        bus.s_bvalid[1] = 1;
        samp();
        chk("t6_idle", {bus.m_rvalid, bus.m_bvalid, bus.s_rready, bus.s_bready}, 6'b0);
        cyc(1);
        bus.s_bvalid = '0;
        bus.m_araddr = 32'h8000_0000; bus.m_arvalid = 1;
        cyc(1);
        bus.m_arvalid = 0; bus.s_rvalid[0] = 1; bus.s_rdata[0] = 32'h0bad_f00d;
        samp();
        chk("t6_read", {31'h0, bus.m_rvalid, bus.m_rdata}, {31'h0, 1'b1, 32'h0bad_f00d});
        cyc(1);
        bus.s_rvalid = '0;

        // decode edges; devices stall AR so hits are not accepted
        bus.s_arready = '0;
        for (int k = 0; k < 5; k++) begin
            bus.m_araddr = dec_addr[k]; bus.m_arvalid = 1;
            samp();
            chk("dec_sel", {bus.s_arvalid, bus.m_arready}, {dec_exp[k], (dec_exp[k] == 2'b00)});
            cyc(1);
            bus.m_arvalid = 0;
            cyc(1);
        end

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_xbar.md
Name: axi_xbar

Overview:
- AXI4-Lite 1-master-to-NSLV-slave address-decoding crossbar. It sits between the single shared AXI4-Lite master port (the arbiter's downstream side) and the memory-mapped devices, e.g. slave0 SRAM and slave1 UART/CLINT.
- Routes each read and each write to the slave selected by address. Unmapped addresses are answered locally with an error response.
- Read and write paths are independent; at most one outstanding read and one outstanding write.

Parameters:
- NSLV, 2, number of slaves.
- ADDR_BASE, {32'ha000_0000, 32'h8000_0000}, packed NSLV*32 base addresses; slice i belongs to slave i.
- ADDR_MASK, {32'hffff_0000, 32'hf800_0000}, packed NSLV*32 masks. Slave i hits when (addr & MASK[i]) == BASE[i].

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
m_arvalid  in  1  master read address valid
m_arready  out  1  master read address ready
m_araddr  in  32  master read address
m_rvalid  out  1  master read data valid
m_rready  in  1  master read data ready
m_rdata  out  32  master read data
m_rresp  out  1  master read response, 1 = error
m_awvalid  in  1  master write address valid
m_awready  out  1  master write address ready
m_awaddr  in  32  master write address
m_wvalid  in  1  master write data valid
m_wready  out  1  master write data ready
m_wdata  in  32  master write data
m_wmask  in  8  master write byte mask
m_bvalid  out  1  master write response valid
m_bready  in  1  master write response ready
m_bresp  out  1  master write response, 1 = error
s_arvalid  out  NSLV  per-slave read address valid
s_arready  in  NSLV  per-slave read address ready
s_araddr  out  32  read address, broadcast to all slaves
s_rvalid  in  NSLV  per-slave read data valid
s_rready  out  NSLV  per-slave read data ready
s_rdata  in  NSLV*32  packed read data; slice i belongs to slave i
s_rresp  in  NSLV  per-slave read response
s_awvalid  out  NSLV  per-slave write address valid
s_awready  in  NSLV  per-slave write address ready
s_awaddr  out  32  write address, broadcast
s_wvalid  out  NSLV  per-slave write data valid
s_wready  in  NSLV  per-slave write data ready
s_wdata  out  32  write data, broadcast
s_wmask  out  8  write mask, broadcast
s_bvalid  in  NSLV  per-slave write response valid
s_bready  out  NSLV  per-slave write response ready
s_bresp  in  NSLV  per-slave write response

Behaviour:
- Decode: combinational on m_araddr / m_awaddr. If several slaves hit, the lowest index wins. No hit is a decode error.
- Reset: read FSM = R_IDLE, write FSM = W_IDLE, selected-slave registers = 0. All valid and ready outputs are 0, except m_arready / m_awready, which follow the decode rules below. m_rdata = 0.
- Read FSM states:
  - R_IDLE
    - Hit i: s_arvalid[i] = m_arvalid and m_arready = s_arready[i]; all other s_arvalid are 0.
    - On handshake: latch sel_r = i, go to R_DATA.
    - Miss: m_arready = m_arvalid; on handshake go to R_ERR.
    - No forwarding to any slave on a miss.
  - R_DATA
    - m_rvalid = s_rvalid[sel_r], m_rdata = slice sel_r, m_rresp = s_rresp[sel_r], s_rready[sel_r] = m_rready.
    - On handshake go to R_IDLE.
    - m_arready = 0 in this state.
  - R_ERR
    - m_rvalid = 1, m_rresp = 1, m_rdata = 0.
    - On m_rready go to R_IDLE.
    - Error rvalid appears 1 cycle after the AR handshake.
- Write FSM states:
  - W_IDLE
    - AW decode is the same as AR. m_wready = 0 always in this state: W is never accepted before AW.
    - Hit: latch sel_w, go to W_DATA.
    - Miss: go to W_ERRW.
  - W_DATA
    - s_wvalid[sel_w] = m_wvalid, m_wready = s_wready[sel_w].
    - On handshake go to W_RESP.
  - W_RESP
    - m_bvalid = s_bvalid[sel_w], m_bresp = s_bresp[sel_w], s_bready[sel_w] = m_bready.
    - On handshake go to W_IDLE.
  - W_ERRW
    - m_wready = 1; W data is discarded.
    - On m_wvalid go to W_ERRB.
  - W_ERRB
    - m_bvalid = 1, m_bresp = 1.
    - On m_bready go to W_IDLE.
- Outside the states above: m_bvalid = 0, m_bresp = 0, m_rresp = 0.
- Latency: the forward path has zero added cycles per channel; the only extra cycle comes from the FSM step between channels. Back-to-back transactions: a new AR is accepted the cycle after the R handshake.
- Read and write FSMs run concurrently, including when both target the same slave.
- Master stall: a stalled m_rready / m_bready holds the FSM state and keeps the slave's valid visible.
- Reset mid-transaction: both FSMs return to idle immediately and the in-flight response is dropped. Slaves are reset by the same signal.

Test Plan:
- Read 0x8000_0010; slave0 raises rvalid 3 cycles after AR with rdata=0x1234_5678 -> m_rdata=0x1234_5678, m_rresp=0; s_arvalid[1] stays 0 throughout.
- Write 0xa000_03f8, wdata=0x41, wmask=0x01; m_wvalid asserted 2 cycles before m_awvalid -> m_wready=0 until AW accepted; slave1 receives data; m_bresp=0.
- Read 0x0000_1000 (unmapped) -> m_arready=1, m_rvalid=1 next cycle with m_rresp=1, m_rdata=0; no s_arvalid asserted.
- Write 0x4000_0000 (unmapped) -> AW and W accepted, then m_bvalid=1, m_bresp=1; no s_awvalid or s_wvalid asserted.
- Concurrent read of slave1 and write to slave0; m_rready held low 4 cycles -> both complete correctly; m_rvalid held stable through the stall.
- Assert reset while in R_DATA and W_RESP -> next cycle: both FSMs idle, all valids 0; a following read of 0x8000_0000 completes normally.
